// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: defaults, FSM state encodings and frame constants shared by uart_tx and the future uart_rx.
package uart_tx_pkg;

    localparam int DEF_CLK_FREQ  = 125_000_000;
    localparam int DEF_BAUD_RATE = 115_200;
    localparam int DATA_BITS     = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic preload_i,
    output logic bit_tick_o
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    // A receiver preloads half a bit so its ticks land mid-bit.
    localparam logic [W-1:0] HALF = W'(CLKS_PER_BIT / 2);

    logic [W-1:0] cnt_q, cnt_d;

    assign bit_tick_o = cnt_q == LAST;

    always_comb cnt_d = clr_i ? '0 : preload_i ? HALF : bit_tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_q;
    logic        serial_q, busy_q, done_q, bit_tick;
`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i      (sysclk),
        .rst_i      (rst),
        .clr_i      (state_q == IDLE),
        .preload_i  (1'b0),
        .bit_tick_o (bit_tick)
    );

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (tx_start) begin
                    state_q  <= START;
                    shift_q  <= tx_data;
                    serial_q <= 1'b0;
                    busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_q <= ^tx_data;
`endif
                end
                START: if (bit_tick) begin
                    state_q  <= DATA;
                    serial_q <= shift_q[0];
                    shift_q  <= shift_q >> 1;
                end
                DATA: if (bit_tick) begin
                    bit_q <= bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_q  <= PARITY;
                        serial_q <= parity_q;
`else
                        state_q  <= STOP;
                        serial_q <= 1'b1;
`endif
                    end else begin
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (bit_tick) begin
                    state_q  <= STOP;
                    serial_q <= 1'b1;
                end
`endif
                STOP: if (bit_tick) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized checks of uart_tx against a bit-timing reference model.
module tb_uart_tx;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FLEN = FB * CPB;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_serial, tx_busy, tx_done;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         inj_k = -1;
    logic [7:0] inj_d = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;
    vec_t vecs[6];

    uart_tx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge sysclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Line level k cycles after the start bit began: start, 8 data bits LSB first, [parity], stop, then idle.
    function automatic logic line_at(input logic [7:0] d, input int k);
        int b;
        b = k / CPB;
        if (k >= FLEN) return 1'b1;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic logic [10:0] model_mid(input logic [7:0] d);
        logic [10:0] m;
        m = '0;
        for (int b = 0; b < FB; b++) m[b] = line_at(d, b * CPB + CPB / 2);
        return m;
    endfunction

    task automatic send(input logic [7:0] d);
        tx_start = 1'b1;
        tx_data  = d;
        tick;
        tx_start = 1'b0;
    endtask

    // Entered just after the accepting edge; leaves on the cycle tx_done is visible.
    task automatic frame(input logic [7:0] d, input logic [10:0] exp_mid, input string nm,
                         output logic [10:0] mid);
        int bad, busy_n, done_n, done_at;
        bad = 0; busy_n = 0; done_n = 0; done_at = -1;
        mid = '0;
        for (int k = 0; k <= FLEN; k++) begin
            if (tx_serial !== line_at(d, k) || tx_busy !== (k < FLEN) || tx_done !== (k == FLEN)) bad++;
            if (tx_busy === 1'b1) busy_n++;
            if (tx_done === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k % CPB == CPB / 2) mid[k / CPB] = tx_serial;
            if (inj_k >= 0 && k == inj_k) begin
                tx_start = 1'b1;
                tx_data  = inj_d;
            end
            if (inj_k >= 0 && k == inj_k + 1) tx_start = 1'b0;
            if (k < FLEN) tick;
        end
        inj_k = -1;
        chk({nm, " mid-bit samples"}, 32'(mid), 32'(exp_mid));
        chk({nm, " trace errors"}, bad, 0);
        chk({nm, " done cycle"}, done_at, FLEN);
        chk({nm, " done pulses"}, done_n, 1);
        chk({nm, " busy cycles"}, busy_n, FLEN);
    endtask

    initial begin
        logic [10:0] mid, exp;
        logic [7:0]  d;
        int          bad;
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h0F, 10'b1000011110};
        vecs[4] = '{8'h55, 10'b1010101010};
        vecs[5] = '{8'h80, 10'b1100000000};

        repeat (3) tick;
        rst = 1'b0;
        chk("reset tx_serial", 32'(tx_serial), 1);
        chk("reset tx_busy", 32'(tx_busy), 0);
        chk("reset tx_done", 32'(tx_done), 0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk("idle hold", bad, 0);

        for (int i = 0; i < 6; i++) begin
            repeat (2) tick;
`ifdef UART_TX_PARITY_EN
            exp = {1'b1, ^vecs[i].data, vecs[i].line[8:0]};
`else
            exp = {1'b0, vecs[i].line};
`endif
            send(vecs[i].data);
            frame(vecs[i].data, exp, $sformatf("table %02h", vecs[i].data), mid);
        end

        tick;
        inj_k = 35;
        inj_d = 8'hFF;
        send(8'h0F);
        frame(8'h0F, model_mid(8'h0F), "ignore busy", mid);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk("ignore busy no requeue", bad, 0);

        tx_start = 1'b1;
        tx_data  = 8'h03;
        tick;
        tx_data = 8'h0C;
        frame(8'h03, model_mid(8'h03), "b2b first", mid);
        tick;
        tx_start = 1'b0;
        frame(8'h0C, model_mid(8'h0C), "b2b second", mid);

        repeat (3) tick;
        send(8'h55);
        repeat (47) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midreset tx_serial", 32'(tx_serial), 1);
        chk("midreset tx_busy", 32'(tx_busy), 0);
        chk("midreset tx_done", 32'(tx_done), 0);
        bad = 0;
        for (int i = 0; i < FLEN + 20; i++) begin
            tick;
            if (tx_serial !== 1'b1 || tx_done !== 1'b0) bad++;
        end
        chk("midreset quiet", bad, 0);
        send(8'h55);
        frame(8'h55, model_mid(8'h55), "after reset", mid);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 4)) tick;
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                inj_k = $urandom_range(1, FLEN - 2);
                inj_d = 8'($urandom);
            end
            send(d);
            frame(d, model_mid(d), $sformatf("random %02h", d), mid);
            tick;
        end

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        frame(8'h07, model_mid(8'h07), "parity 07", mid);
        chk("parity bit 07", 32'(mid[9]), 1);
        tick;
        send(8'h03);
        frame(8'h03, model_mid(8'h03), "parity 03", mid);
        chk("parity bit 03", 32'(mid[9]), 0);
`endif

        repeat (2) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
